// File: rtl/led_status_ctrl.sv
// led_status_ctrl: drives the four board LEDs from UART events.
//   led[0] heartbeat, led[1] TX activity, led[2] RX activity, led[3] error blink.
// All LED outputs are active-low and registered; en[i]=0 forces led[i] off
// without disturbing any internal counter or the error FSM.
`timescale 1ns/1ps

module led_status_ctrl #(
  parameter int CLK_HZ        = 1000000,
  parameter int TICK_HZ       = 1000,
  parameter int STRETCH_TICKS = 50,
  parameter int BLINK_TICKS   = 250,
  parameter int ERR_BLINKS    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_pulse,
  input  logic       rx_pulse,
  input  logic       err_pulse,
  input  logic [3:0] en,
  output logic [3:0] led,
  output logic       err_active
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HB_W  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int STR_W = $clog2(STRETCH_TICKS + 1);
  localparam int PH_W  = $clog2(BLINK_TICKS + 1);
  localparam int BLK_W = $clog2(ERR_BLINKS + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [HB_W-1:0]  HB_LAST  = HB_W'(BLINK_TICKS - 1);
  localparam logic [STR_W-1:0] STR_LOAD = STR_W'(STRETCH_TICKS);
  localparam logic [PH_W-1:0]  PH_LOAD  = PH_W'(BLINK_TICKS);
  localparam logic [BLK_W-1:0] BLK_LOAD = BLK_W'(ERR_BLINKS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } err_state_t;

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic [HB_W-1:0]  hb_cnt;
  logic             hb;
  logic [STR_W-1:0] str_cnt [2];
  logic [1:0]       strobe;
  err_state_t       state;
  logic [PH_W-1:0]  ph_cnt;
  logic [BLK_W-1:0] blk_left;
  logic [3:0]       lit;

  // One-cycle tick in the last cycle of each prescaler period.
  assign tick   = (pre_cnt == PRE_LAST);
  // Index 0 is the TX stretcher, index 1 the RX stretcher.
  assign strobe = {rx_pulse, tx_pulse};

  // Prescaler: free-running 0..DIV-1.
  // NOTE: sequential state always uses non-blocking (<=) so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // Heartbeat: toggle hb every BLINK_TICKS ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hb_cnt <= '0;
      hb     <= 1'b0;
    end else if (tick) begin
      if (hb_cnt == HB_LAST) begin
        hb_cnt <= '0;
        hb     <= ~hb;
      end else begin
        hb_cnt <= hb_cnt + 1'b1;
      end
    end
  end

  // Activity stretchers: a strobe reloads, ticks count down to zero; load wins.
  // NOTE: these counters are plain registers, not a RAM, so every entry is
  // reset explicitly; nothing may survive a reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        str_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (strobe[i]) begin
          str_cnt[i] <= STR_LOAD;
        end else if (tick && (str_cnt[i] != '0)) begin
          str_cnt[i] <= str_cnt[i] - 1'b1;
        end
      end
    end
  end

  // Error blinker FSM; err_pulse restarts from any state and beats a tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      ph_cnt     <= '0;
      blk_left   <= '0;
      err_active <= 1'b0;
    end else if (err_pulse) begin
      state      <= S_ON;
      ph_cnt     <= PH_LOAD;
      blk_left   <= BLK_LOAD;
      err_active <= 1'b1;
    end else if (tick) begin
      case (state)
        S_ON: begin
          if (ph_cnt == PH_W'(1)) begin
            state  <= S_OFF;
            ph_cnt <= PH_LOAD;
          end else if (ph_cnt != '0) begin
            ph_cnt <= ph_cnt - 1'b1;
          end
        end
        S_OFF: begin
          if (ph_cnt == PH_W'(1)) begin
            if (blk_left <= BLK_W'(1)) begin
              state      <= S_IDLE;
              ph_cnt     <= '0;
              blk_left   <= '0;
              err_active <= 1'b0;
            end else begin
              state    <= S_ON;
              ph_cnt   <= PH_LOAD;
              blk_left <= blk_left - 1'b1;
            end
          end else if (ph_cnt != '0) begin
            ph_cnt <= ph_cnt - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Which LEDs would be lit before masking.
  assign lit = {state == S_ON, str_cnt[1] != '0, str_cnt[0] != '0, hb};

  // Registered, active-low, enable-gated LED drive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led <= 4'b1111;
    end else begin
      led <= ~(lit & en);
    end
  end

endmodule

// File: tb/tb_led_status_ctrl.sv
// Scoreboard bench for led_status_ctrl. Stimulus pushes the expected edge
// (cycle number and new value) of every output bit into per-signal queues;
// a monitor watches the outputs on the falling clock edge and pops an entry
// each time a bit changes. Bits 0..3 are led[3:0], bit 4 is err_active.
`timescale 1ns/1ps

module tb_led_status_ctrl;

  typedef struct {
    int   cyc;
    logic v;
  } ev_t;

  logic       clk;
  logic       reset;
  logic       tx_pulse;
  logic       rx_pulse;
  logic       err_pulse;
  logic [3:0] en;
  logic [3:0] led;
  logic       err_active;

  int   errors = 0;
  int   checks = 0;
  int   cyc;
  ev_t  exq [5][$];
  logic [4:0] prev_sig;
  logic [4:0] cur_sig;

  led_status_ctrl #(
    .CLK_HZ       (100),
    .TICK_HZ      (10),
    .STRETCH_TICKS(3),
    .BLINK_TICKS  (2),
    .ERR_BLINKS   (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_pulse  (tx_pulse),
    .rx_pulse  (rx_pulse),
    .err_pulse (err_pulse),
    .en        (en),
    .led       (led),
    .err_active(err_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle number = rising edges since reset release.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic push(input int b, input int c, input logic v);
    ev_t e;
    e.cyc = c;
    e.v   = v;
    exq[b].push_back(e);
  endtask

  task automatic check_overdue();
    int n = 0;
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < exq[b].size(); i++) begin
        if (exq[b][i].cyc < cyc) n++;
      end
    end
    check("missed output edges", n, 0);
  endtask

  task automatic at(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Strobe sampled by the rising edge numbered k.
  task automatic pulse_at(input int k, input int which);
    at(k - 1);
    case (which)
      0: tx_pulse = 1'b1;
      1: rx_pulse = 1'b1;
      default: err_pulse = 1'b1;
    endcase
    at(k);
    tx_pulse  = 1'b0;
    rx_pulse  = 1'b0;
    err_pulse = 1'b0;
  endtask

  // Monitor: every output bit change is matched against its queue.
  initial begin
    prev_sig = 5'b01111;
    forever begin
      @(negedge clk);
      cur_sig = {err_active, led};
      if (reset) begin
        prev_sig = cur_sig;
      end else begin
        for (int b = 0; b < 5; b++) begin
          if (cur_sig[b] !== prev_sig[b]) begin
            if (exq[b].size() == 0) begin
              check($sformatf("sig%0d unexpected change", b), int'(cur_sig[b]), int'(prev_sig[b]));
            end else begin
              ev_t e;
              e = exq[b].pop_front();
              check($sformatf("sig%0d edge cycle", b), cyc, e.cyc);
              check($sformatf("sig%0d edge value", b), int'(cur_sig[b]), int'(e.v));
            end
          end
        end
        prev_sig = cur_sig;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    tx_pulse  = 1'b0;
    rx_pulse  = 1'b0;
    err_pulse = 1'b0;
    en        = 4'b1111;
    repeat (3) @(negedge clk);
    check("led in reset", int'(led), 4'b1111);
    check("err_active in reset", int'(err_active), 0);

    // Heartbeat: ticks land on edges 10,20,...; hb toggles every 2nd tick,
    // led[0] low after edges 21+40j, high after 41+40j. During the en=0
    // window (edges 346..362) led[0] is forced off early, and hb is already
    // dark when the mask lifts, so the 361 edge disappears.
    for (int j = 0; j <= 10; j++) begin
      if (j == 8) begin
        push(0, 341, 1'b0);
        push(0, 346, 1'b1);
      end else begin
        push(0, 21 + 40 * j, 1'b0);
        push(0, 41 + 40 * j, 1'b1);
      end
    end
    // TX: pulse at 33 -> low 34..60; gated pulse at 353 shows at 363, ends 381;
    // last pulse at 402 shows at 403 (aborted by reset).
    push(1, 34, 1'b0);  push(1, 61, 1'b1);
    push(1, 363, 1'b0); push(1, 381, 1'b1);
    push(1, 403, 1'b0);
    // RX: load at tick 70, retrigger at 85, three ticks later (110) it clears.
    push(2, 71, 1'b0);  push(2, 111, 1'b1);
    // Error: single pulse at 120, then pulse at 220 restarted during OFF at 250.
    push(3, 121, 1'b0); push(3, 141, 1'b1); push(3, 161, 1'b0); push(3, 181, 1'b1);
    push(3, 221, 1'b0); push(3, 241, 1'b1);
    push(3, 251, 1'b0); push(3, 271, 1'b1); push(3, 291, 1'b0); push(3, 311, 1'b1);
    push(3, 401, 1'b0);
    push(4, 120, 1'b1); push(4, 200, 1'b0);
    push(4, 220, 1'b1); push(4, 330, 1'b0);
    push(4, 400, 1'b1);

    reset = 1'b0;

    pulse_at(33, 0);
    pulse_at(70, 1);
    pulse_at(85, 1);
    pulse_at(120, 2);
    pulse_at(220, 2);
    pulse_at(250, 2);

    at(345);
    en = 4'b0000;
    pulse_at(353, 0);
    at(362);
    en = 4'b1111;

    pulse_at(400, 2);
    pulse_at(402, 0);
    at(405);
    check_overdue();

    // Asynchronous reset between edges, error ON and TX lit.
    #2;
    reset = 1'b1;
    #1;
    check("led after async reset", int'(led), 4'b1111);
    check("err_active after async reset", int'(err_active), 0);
    for (int b = 0; b < 5; b++) exq[b].delete();

    // Fresh run: only the heartbeat may move.
    for (int j = 0; j <= 3; j++) begin
      push(0, 21 + 40 * j, 1'b0);
      push(0, 41 + 40 * j, 1'b1);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    at(140);
    check_overdue();
    check("err_active stays idle", int'(err_active), 0);
    check("led[3] stays dark", int'(led[3]), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
